// File: rtl/score_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_tracker_pkg
// Description : Shared constants for the Scream-at-Snake score tracker:
//               state encoding, default scoring parameters, BCD digit width
//               and pending-counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package score_tracker_pkg;

    // State encoding
    localparam int c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_STOP = 2'd0;  // idle after reset
    localparam state_t c_ST_RUN  = 2'd1;  // accepting events
    localparam state_t c_ST_ADD  = 2'd2;  // applying pending points
    localparam state_t c_ST_OVER = 2'd3;  // frozen after a game

    // Scoring defaults
    localparam int c_MAX_SCORE_DEF   = 255;
    localparam int c_FOOD_POINTS_DEF = 1;

    // One BCD decade
    localparam int c_BCD_W = 4;

    // Pending-points accumulator
    localparam int c_PENDING_W   = 8;
    localparam int c_PENDING_MAX = 255;

endpackage : score_tracker_pkg
`default_nettype wire

// File: rtl/score_tracker_bcd_digit_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_counter
// Description : Single BCD decade counter, 0..9 with wrap and carry-out.
//               Chained in ripple fashion to form a multi-digit counter.
// Ports       : clk      - system clock
//               resetn   - asynchronous active-low reset
//               i_clr    - synchronous clear (wins over increment)
//               i_en     - increment enable
//               i_carry  - carry-in from the lower decade (tie 1 for ones)
//               o_digit  - current BCD digit
//               o_carry  - carry-out: this digit wraps 9->0 on this edge
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_counter
    import score_tracker_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic               i_carry,
    output logic [c_BCD_W-1:0] o_digit,
    output logic               o_carry
);

    localparam logic [c_BCD_W-1:0] c_DIGIT_MAX = 4'd9;
    localparam logic [c_BCD_W-1:0] c_ONE       = 4'd1;

    logic [c_BCD_W-1:0] r_digit;
    logic               w_step;

    assign w_step = i_en & i_carry;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_digit <= '0;
        end else if (i_clr) begin
            r_digit <= '0;
        end else if (w_step) begin
            r_digit <= (r_digit == c_DIGIT_MAX) ? '0 : r_digit + c_ONE;
        end
    end

    assign o_digit = r_digit;
    assign o_carry = w_step & (r_digit == c_DIGIT_MAX);

endmodule : bcd_digit_counter
`default_nettype wire

// File: rtl/score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : score_tracker
// Description : Running score for Scream-at-Snake. Food and bonus pulses are
//               accumulated into a saturating pending counter and applied one
//               point per cycle, keeping a binary score and a three-digit BCD
//               copy in lockstep. Tracks game start/over and the session high
//               score.
// Ports       : clk, resetn           - clock, async active-low reset
//               game_start, game_over - one-cycle control pulses
//               food_eaten            - credits FOOD_POINTS
//               bonus_valid/bonus_amt - credits bonus_amt
//               score                 - binary score
//               score_hund/tens/ones  - BCD digits of score
//               high_score, new_high  - best score, last game beat it
//               busy, running         - in ADD, in RUN or ADD
// Revision    : 1.0 - initial release
// ============================================================================
module score_tracker
    import score_tracker_pkg::*;
#(
    parameter int SCORE_W     = 8,
    parameter int MAX_SCORE   = c_MAX_SCORE_DEF,
    parameter int FOOD_POINTS = c_FOOD_POINTS_DEF,
    parameter int BONUS_W     = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               game_start,
    input  logic               game_over,
    input  logic               food_eaten,
    input  logic               bonus_valid,
    input  logic [BONUS_W-1:0] bonus_amt,
    output logic [SCORE_W-1:0] score,
    output logic [c_BCD_W-1:0] score_hund,
    output logic [c_BCD_W-1:0] score_tens,
    output logic [c_BCD_W-1:0] score_ones,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic               busy,
    output logic               running
);

    // Wide enough for pending + the largest single-cycle credit
    localparam int c_SUM_W = 10;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_PENDING_W-1:0]   r_pending;
    logic [c_PENDING_W-1:0]   w_pending_nxt;
    logic [SCORE_W-1:0]       r_score;
    logic [SCORE_W-1:0]       r_high;
    logic [SCORE_W-1:0]       w_high_nxt;
    logic                     r_new_high;
    logic                     w_new_high_nxt;
    logic                     r_busy;
    logic                     r_running;

    logic                     w_clr;
    logic                     w_inc;
    logic                     w_active;
    logic                     w_at_max;
    logic                     w_last_inc;
    logic [c_SUM_W-1:0]       w_credit;
    logic [c_SUM_W-1:0]       w_sum;
    logic [c_PENDING_W-1:0]   w_pending_sat;
    logic [c_PENDING_W-1:0]   w_pending_dec;

    assign w_active   = (r_state == c_ST_RUN) || (r_state == c_ST_ADD);
    assign w_at_max   = (r_score == SCORE_W'(MAX_SCORE));
    assign w_last_inc = (r_score == SCORE_W'(MAX_SCORE - 1));

    assign w_credit = (food_eaten  ? c_SUM_W'(FOOD_POINTS) : '0)
                    + (bonus_valid ? c_SUM_W'(bonus_amt)   : '0);
    assign w_sum    = c_SUM_W'(r_pending) + w_credit;

    assign w_pending_sat = (w_sum > c_SUM_W'(c_PENDING_MAX))
                         ? c_PENDING_W'(c_PENDING_MAX)
                         : w_sum[c_PENDING_W-1:0];
    // Only used in ADD, where pending is at least 1, so this cannot wrap
    assign w_pending_dec = w_pending_sat - c_PENDING_W'(1);

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_ST_STOP;
            r_pending  <= '0;
            r_score    <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
            r_busy     <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_high     <= w_high_nxt;
            r_new_high <= w_new_high_nxt;
            r_busy     <= (w_state_nxt == c_ST_ADD);
            r_running  <= (w_state_nxt == c_ST_RUN) || (w_state_nxt == c_ST_ADD);
            if (w_clr) begin
                r_score <= '0;
            end else if (w_inc) begin
                r_score <= r_score + SCORE_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_high_nxt     = r_high;
        w_new_high_nxt = r_new_high;
        w_clr          = 1'b0;
        w_inc          = 1'b0;

        if (game_start) begin
            w_clr          = 1'b1;
            w_pending_nxt  = '0;
            w_new_high_nxt = 1'b0;
            w_state_nxt    = c_ST_RUN;
        end else if (game_over && w_active) begin
            // Score is frozen on this edge; compare against its current value
            w_pending_nxt  = '0;
            w_state_nxt    = c_ST_OVER;
            w_new_high_nxt = (r_score > r_high);
            if (r_score > r_high) begin
                w_high_nxt = r_score;
            end
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_at_max) begin
                        // Saturated: credit is discarded
                        w_pending_nxt = '0;
                    end else begin
                        w_pending_nxt = w_pending_sat;
                        if (w_pending_sat != '0) begin
                            w_state_nxt = c_ST_ADD;
                        end
                    end
                end
                c_ST_ADD: begin
                    if (w_at_max) begin
                        w_pending_nxt = '0;
                        w_state_nxt   = c_ST_RUN;
                    end else begin
                        w_inc = 1'b1;
                        // Reaching MAX_SCORE on this edge drops whatever is left
                        if (w_last_inc || (w_pending_dec == '0)) begin
                            w_pending_nxt = '0;
                            w_state_nxt   = c_ST_RUN;
                        end else begin
                            w_pending_nxt = w_pending_dec;
                        end
                    end
                end
                default: begin
                    // STOP and OVER ignore events
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // BCD copy of the score: ones -> tens -> hundreds ripple chain
    // ------------------------------------------------------------------
    logic [c_BCD_W-1:0] w_digit [3];
    logic [3:0]         w_carry;

    assign w_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            bcd_digit_counter u_digit (
                .clk     (clk),
                .resetn  (resetn),
                .i_clr   (w_clr),
                .i_en    (w_inc),
                .i_carry (w_carry[gi]),
                .o_digit (w_digit[gi]),
                .o_carry (w_carry[gi+1])
            );
        end
    endgenerate

    assign score      = r_score;
    assign score_ones = w_digit[0];
    assign score_tens = w_digit[1];
    assign score_hund = w_digit[2];
    assign high_score = r_high;
    assign new_high   = r_new_high;
    assign busy       = r_busy;
    assign running    = r_running;

endmodule : score_tracker
`default_nettype wire

// File: tb/tb_score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_tracker
// Description : Self-checking bench for score_tracker. A game-level model
//               (score, pending points, playing flag, high score) predicts
//               every output each cycle; directed scenarios pin the model
//               with literal values, followed by a randomized session.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_tracker;

    logic       clk = 1'b0;
    logic       resetn;
    logic       game_start, game_over, food_eaten, bonus_valid;
    logic [3:0] bonus_amt;
    logic [7:0] score, high_score;
    logic [3:0] score_hund, score_tens, score_ones;
    logic       new_high, busy, running;

    always #5 clk = ~clk;

    score_tracker #(
        .SCORE_W     (8),
        .MAX_SCORE   (255),
        .FOOD_POINTS (1),
        .BONUS_W     (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .game_start  (game_start),
        .game_over   (game_over),
        .food_eaten  (food_eaten),
        .bonus_valid (bonus_valid),
        .bonus_amt   (bonus_amt),
        .score       (score),
        .score_hund  (score_hund),
        .score_tens  (score_tens),
        .score_ones  (score_ones),
        .high_score  (high_score),
        .new_high    (new_high),
        .busy        (busy),
        .running     (running)
    );

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Game-level reference model
    // ------------------------------------------------------------------
    int m_score, m_pending, m_high;
    bit m_playing, m_new;
    int n_score, n_pending, n_high;
    bit n_playing, n_new;
    int credit;

    function automatic int cap255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    always_comb begin
        n_score   = m_score;
        n_pending = m_pending;
        n_high    = m_high;
        n_playing = m_playing;
        n_new     = m_new;
        credit    = (food_eaten ? 1 : 0) + (bonus_valid ? int'(bonus_amt) : 0);
        if (game_start) begin
            n_playing = 1'b1;
            n_score   = 0;
            n_pending = 0;
            n_new     = 1'b0;
        end else if (game_over && m_playing) begin
            n_playing = 1'b0;
            n_pending = 0;
            n_new     = (m_score > m_high);
            if (m_score > m_high) n_high = m_score;
        end else if (m_playing) begin
            if (m_pending > 0) begin
                n_score   = m_score + 1;
                n_pending = cap255(m_pending + credit) - 1;
            end else begin
                n_pending = cap255(credit);
            end
            if (n_score >= 255) n_pending = 0;
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_score   <= 0;
            m_pending <= 0;
            m_high    <= 0;
            m_playing <= 1'b0;
            m_new     <= 1'b0;
        end else begin
            m_score   <= n_score;
            m_pending <= n_pending;
            m_high    <= n_high;
            m_playing <= n_playing;
            m_new     <= n_new;
        end
    end

    // Cycle-by-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("score",      int'(score),      m_score);
            check("score_hund", int'(score_hund), m_score / 100);
            check("score_tens", int'(score_tens), (m_score / 10) % 10);
            check("score_ones", int'(score_ones), m_score % 10);
            check("high_score", int'(high_score), m_high);
            check("new_high",   int'(new_high),   int'(m_new));
            check("busy",       int'(busy),       int'(m_playing && (m_pending > 0)));
            check("running",    int'(running),    int'(m_playing));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change on the falling edge
    // ------------------------------------------------------------------
    task automatic step(input bit gs, input bit go, input bit fe, input bit bv, input int ba);
        game_start  = gs;
        game_over   = go;
        food_eaten  = fe;
        bonus_valid = bv;
        bonus_amt   = 4'(ba);
        @(negedge clk);
        if (busy) busy_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic check_digits(input string tag, input int h, input int t, input int o);
        check({tag, "_hund"}, int'(score_hund), h);
        check({tag, "_tens"}, int'(score_tens), t);
        check({tag, "_ones"}, int'(score_ones), o);
    endtask

    initial begin
        resetn = 1'b0;
        game_start = 1'b0; game_over = 1'b0; food_eaten = 1'b0;
        bonus_valid = 1'b0; bonus_amt = '0;
        repeat (3) @(negedge clk);
        check("rst_score", int'(score), 0);
        check("rst_high", int'(high_score), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_running", int'(running), 0);
        resetn = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Three spaced food pulses
        step(1, 0, 0, 0, 0);
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0);
            idle(3);
        end
        check("t1_score", int'(score), 3);
        check_digits("t1", 0, 0, 3);
        check("t1_busy_cycles", busy_cnt, 3);

        // Bonus 15 plus food together
        step(1, 0, 0, 0, 0);
        busy_cnt = 0;
        step(0, 0, 1, 1, 15);
        idle(20);
        check("t2_score", int'(score), 16);
        check_digits("t2", 0, 1, 6);
        check("t2_busy_cycles", busy_cnt, 16);

        // 99 -> 100 rollover
        step(1, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 1, 15);
        step(0, 0, 0, 1, 9);
        idle(110);
        check("t3_score99", int'(score), 99);
        step(0, 0, 1, 0, 0);
        idle(1);
        check("t3_score100", int'(score), 100);
        check_digits("t3", 1, 0, 0);

        // Saturation at 255
        step(1, 0, 0, 0, 0);
        repeat (20) step(0, 0, 0, 1, 15);
        idle(300);
        check("t4_score", int'(score), 255);
        check_digits("t4", 2, 5, 5);
        busy_cnt = 0;
        step(0, 0, 1, 1, 7);
        idle(3);
        check("t4_score_after", int'(score), 255);
        check("t4_busy_cycles", busy_cnt, 0);
        check("t4_running", int'(running), 1);

        // High score across three games: 20, 12, 20
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 15); step(0, 0, 0, 1, 5);
        idle(25);
        step(0, 1, 0, 0, 0);
        check("t5_g1_high", int'(high_score), 20);
        check("t5_g1_new", int'(new_high), 1);
        check("t5_g1_running", int'(running), 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 12);
        idle(20);
        step(0, 1, 0, 0, 0);
        check("t5_g2_high", int'(high_score), 20);
        check("t5_g2_new", int'(new_high), 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 15); step(0, 0, 0, 1, 5);
        idle(25);
        step(0, 1, 0, 0, 0);
        check("t5_g3_high", int'(high_score), 20);
        check("t5_g3_new", int'(new_high), 0);

        // game_over while 7 points are still pending
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 15);
        idle(8);
        check("t6_score_pre", int'(score), 8);
        step(0, 1, 0, 0, 0);
        idle(5);
        check("t6_score_frozen", int'(score), 8);
        check("t6_busy", int'(busy), 0);
        check("t6_running", int'(running), 0);

        // Asynchronous reset in the middle of ADD
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 15);
        idle(3);
        check("t7_busy_pre", int'(busy), 1);
        #2 resetn = 1'b0;
        #1;
        check("t7_score", int'(score), 0);
        check_digits("t7", 0, 0, 0);
        check("t7_high", int'(high_score), 0);
        check("t7_new", int'(new_high), 0);
        check("t7_busy", int'(busy), 0);
        check("t7_running", int'(running), 0);
        @(negedge clk);
        resetn = 1'b1;
        idle(2);

        // game_start and game_over together: start wins
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5);
        idle(2);
        step(1, 1, 0, 0, 0);
        check("t8_running", int'(running), 1);
        check("t8_score", int'(score), 0);
        check("t8_busy", int'(busy), 0);

        // Randomized session
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 47) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 15)));
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_score_tracker
`default_nettype wire
